// File: rtl/dlsc_pcie_s6_outbound_arb.sv
// rtl/dlsc_pcie_s6_outbound_arb.sv - round-robin TLP arbiter for the Spartan-6 PCIe transmit stream
//
// Purpose: shares the core's 32-bit transmit stream among completion (cpl), posted write (wr)
// and non-posted read (rd) TLP sources. Grants happen only at TLP boundaries, in round-robin
// order, gated by core buffer availability; core config-completion requests take precedence.
//
// Ports:
//   clk, rst_n                         user clock, asynchronous active-low reset
//   tx_ready/valid/last/data           stream to core s_axis_tx
//   tx_buf_av                          core transmit buffers available
//   tx_cfg_req / tx_cfg_gnt            core config-completion handshake
//   tx_err_drop                        core dropped-TLP pulse
//   {cpl,wr,rd}_ready/valid/last/data  source streams
//   busy                               arbiter not idle
//   drop_count                         saturating count of dropped TLPs

module dlsc_pcie_s6_outbound_arb #(
    parameter int BUF_MIN    = 1,
    parameter int NP_BUF_MIN = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        tx_ready,
    output logic        tx_valid,
    output logic        tx_last,
    output logic [31:0] tx_data,
    input  logic [5:0]  tx_buf_av,
    input  logic        tx_cfg_req,
    output logic        tx_cfg_gnt,
    input  logic        tx_err_drop,

    output logic        cpl_ready,
    input  logic        cpl_valid,
    input  logic        cpl_last,
    input  logic [31:0] cpl_data,

    output logic        wr_ready,
    input  logic        wr_valid,
    input  logic        wr_last,
    input  logic [31:0] wr_data,

    output logic        rd_ready,
    input  logic        rd_valid,
    input  logic        rd_last,
    input  logic [31:0] rd_data,

    output logic        busy,
    output logic [7:0]  drop_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_CFG  = 2'd2
    } state_t;

    localparam logic [1:0] SRC_CPL = 2'd0;
    localparam logic [1:0] SRC_WR  = 2'd1;
    localparam logic [1:0] SRC_RD  = 2'd2;

    localparam logic [5:0] BUF_MIN_L    = 6'(BUF_MIN);
    localparam logic [5:0] NP_BUF_MIN_L = 6'(NP_BUF_MIN);

    function automatic logic [1:0] rr_next(input logic [1:0] s);
        case (s)
            SRC_CPL: return SRC_WR;
            SRC_WR:  return SRC_RD;
            default: return SRC_CPL;
        endcase
    endfunction

    state_t     state;
    logic [1:0] sel;
    // rr_ptr holds the source with highest priority at the next arbitration,
    // i.e. the one following the most recently granted source.
    logic [1:0] rr_ptr;

    // Bit 3 is a permanent zero so a 2-bit index never reaches past the vector.
    logic [3:0] elig;
    logic [1:0] ord1, ord2;
    logic       pick_valid;
    logic [1:0] pick_src;

    always_comb begin
        elig       = 4'b0000;
        elig[0]    = cpl_valid && (tx_buf_av >= BUF_MIN_L);
        elig[1]    = wr_valid  && (tx_buf_av >= BUF_MIN_L);
        elig[2]    = rd_valid  && (tx_buf_av >= NP_BUF_MIN_L);
        ord1       = rr_next(rr_ptr);
        ord2       = rr_next(ord1);
        pick_valid = 1'b1;
        pick_src   = rr_ptr;
        if (elig[rr_ptr]) begin
            pick_src = rr_ptr;
        end else if (elig[ord1]) begin
            pick_src = ord1;
        end else if (elig[ord2]) begin
            pick_src = ord2;
        end else begin
            pick_valid = 1'b0;
        end
    end

    logic        in_xfer;
    logic        sel_valid;
    logic        sel_last;
    logic [31:0] sel_data;

    always_comb begin
        in_xfer = (state == ST_XFER);
        case (sel)
            SRC_CPL: begin sel_valid = cpl_valid; sel_last = cpl_last; sel_data = cpl_data; end
            SRC_WR:  begin sel_valid = wr_valid;  sel_last = wr_last;  sel_data = wr_data;  end
            default: begin sel_valid = rd_valid;  sel_last = rd_last;  sel_data = rd_data;  end
        endcase
        tx_valid  = in_xfer && sel_valid;
        tx_last   = in_xfer && sel_last;
        tx_data   = in_xfer ? sel_data : 32'd0;
        cpl_ready = in_xfer && (sel == SRC_CPL) && tx_ready;
        wr_ready  = in_xfer && (sel == SRC_WR)  && tx_ready;
        rd_ready  = in_xfer && (sel == SRC_RD)  && tx_ready;
        busy      = (state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            sel        <= SRC_CPL;
            rr_ptr     <= SRC_CPL;
            tx_cfg_gnt <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (tx_cfg_req) begin
                        state      <= ST_CFG;
                        tx_cfg_gnt <= 1'b1;
                    end else if (pick_valid) begin
                        sel    <= pick_src;
                        rr_ptr <= rr_next(pick_src);
                        state  <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    // Config requests and buffer levels are not looked at here: a TLP is never cut.
                    if (tx_valid && tx_ready && tx_last) begin
                        state <= ST_IDLE;
                    end
                end
                ST_CFG: begin
                    if (!tx_cfg_req) begin
                        tx_cfg_gnt <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    tx_cfg_gnt <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= 8'd0;
        end else if (tx_err_drop && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_dlsc_pcie_s6_outbound_arb.sv
// tb/tb_dlsc_pcie_s6_outbound_arb.sv - self-checking bench for dlsc_pcie_s6_outbound_arb

module tb_dlsc_pcie_s6_outbound_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx_ready = 1'b0;
    logic        tx_valid, tx_last;
    logic [31:0] tx_data;
    logic [5:0]  tx_buf_av = 6'd0;
    logic        tx_cfg_req = 1'b0;
    logic        tx_cfg_gnt;
    logic        tx_err_drop = 1'b0;
    logic        cpl_ready, wr_ready, rd_ready;
    logic        sv [3];
    logic        sl [3];
    logic [31:0] sd [3];
    logic        busy;
    logic [7:0]  drop_count;

    always #5 clk = ~clk;

    dlsc_pcie_s6_outbound_arb #(.BUF_MIN(1), .NP_BUF_MIN(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_last(tx_last), .tx_data(tx_data),
        .tx_buf_av(tx_buf_av), .tx_cfg_req(tx_cfg_req), .tx_cfg_gnt(tx_cfg_gnt),
        .tx_err_drop(tx_err_drop),
        .cpl_ready(cpl_ready), .cpl_valid(sv[0]), .cpl_last(sl[0]), .cpl_data(sd[0]),
        .wr_ready(wr_ready),   .wr_valid(sv[1]),  .wr_last(sl[1]),  .wr_data(sd[1]),
        .rd_ready(rd_ready),   .rd_valid(sv[2]),  .rd_last(sl[2]),  .rd_data(sd[2]),
        .busy(busy), .drop_count(drop_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct packed { logic [31:0] data; logic last; } beat_t;
    typedef struct packed { logic [31:0] data; logic last; } exp_t;
    beat_t srcq [3][$];
    exp_t  exp_q [$];

    logic drv_en = 1'b0;
    logic mon_en = 1'b0;
    logic gap_en = 1'b0;
    logic tog_en = 1'b0;
    int   hs_count = 0;

    // Queue one TLP on source s; expected beats go to the scoreboard in call order,
    // so tests call load() in the order the arbiter is expected to grant.
    task automatic load(input int s, input int n, input int tag);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = (32'(s + 1) << 24) | (32'(tag) << 8) | 32'(i);
            b.last = (i == n - 1);
            srcq[s].push_back(b);
            exp_q.push_back('{data: b.data, last: b.last});
        end
    endtask

    // Source driver: presents the head of each source queue, pops on handshake.
    always begin : src_drv
        logic took [3];
        logic rdy [3];
        @(negedge clk);
        rdy[0] = cpl_ready; rdy[1] = wr_ready; rdy[2] = rd_ready;
        for (int s = 0; s < 3; s++) took[s] = drv_en && rst_n && sv[s] && rdy[s];
        @(posedge clk);
        #1;
        if (tog_en) tx_ready = ~tx_ready;
        if (drv_en) begin
            for (int s = 0; s < 3; s++) begin
                if (took[s] && srcq[s].size() > 0) void'(srcq[s].pop_front());
                if (srcq[s].size() > 0) begin
                    sv[s] = 1'b1; sd[s] = srcq[s][0].data; sl[s] = srcq[s][0].last;
                end else begin
                    sv[s] = 1'b0; sd[s] = 32'd0; sl[s] = 1'b0;
                end
            end
        end
    end

    // Output monitor / scoreboard consumer.
    int   cyc = 0;
    int   last_cyc = 0;
    logic have_last = 1'b0;
    logic in_tlp = 1'b0;

    always @(negedge clk) begin : mon
        exp_t e;
        cyc++;
        if (!rst_n) begin
            in_tlp = 1'b0;
        end else begin
            if (mon_en && tx_valid && tx_ready) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_beat actual=%0h expected=none", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_data", 64'(tx_data), 64'(e.data));
                    chk("sb_last", 64'(tx_last), 64'(e.last));
                end
                if (gap_en && !in_tlp && have_last) chk("idle_gap", 64'(cyc - last_cyc), 64'd2);
                in_tlp = !tx_last;
                if (tx_last) begin
                    last_cyc  = cyc;
                    have_last = 1'b1;
                end
            end
            if (mon_en && (cpl_ready || wr_ready || rd_ready))
                chk("ready_onehot", 64'(int'(cpl_ready) + int'(wr_ready) + int'(rd_ready)), 64'd1);
            if (tog_en && busy)
                chk("bp_ready", 64'({cpl_ready, wr_ready, rd_ready}), 64'({tx_ready, 2'b00}));
        end
    end

    task automatic clear_src;
        drv_en = 1'b0;
        for (int s = 0; s < 3; s++) begin
            srcq[s].delete();
            sv[s] = 1'b0; sl[s] = 1'b0; sd[s] = 32'd0;
        end
        exp_q.delete();
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        clear_src();
        mon_en = 1'b0; gap_en = 1'b0; tog_en = 1'b0;
        tx_cfg_req = 1'b0; tx_err_drop = 1'b0;
        hs_count = 0; have_last = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic wait_drain(input string nm, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk(nm, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_hs(input int target, input int budget);
        int n = 0;
        while (hs_count < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk("wait_hs", 64'(hs_count), 64'(target));
    endtask

    // IDLE arbitration vectors, each applied right after reset (rr pointer at cpl).
    // exp = {cpl_ready, wr_ready, rd_ready, tx_cfg_gnt, busy} one cycle later with tx_ready=1.
    typedef struct packed {
        logic [2:0] v;     // {rd, wr, cpl} valid
        logic [5:0] av;
        logic       cfg;
        logic [4:0] exp;
    } vec_t;

    vec_t vt [11];

    initial begin
        for (int s = 0; s < 3; s++) begin sv[s] = 1'b0; sl[s] = 1'b0; sd[s] = 32'd0; end

        vt[0]  = '{v: 3'b111, av: 6'd10, cfg: 1'b0, exp: 5'b10001};
        vt[1]  = '{v: 3'b110, av: 6'd10, cfg: 1'b0, exp: 5'b01001};
        vt[2]  = '{v: 3'b100, av: 6'd3,  cfg: 1'b0, exp: 5'b00000};
        vt[3]  = '{v: 3'b100, av: 6'd4,  cfg: 1'b0, exp: 5'b00101};
        vt[4]  = '{v: 3'b001, av: 6'd1,  cfg: 1'b0, exp: 5'b10001};
        vt[5]  = '{v: 3'b001, av: 6'd0,  cfg: 1'b0, exp: 5'b00000};
        vt[6]  = '{v: 3'b010, av: 6'd0,  cfg: 1'b0, exp: 5'b00000};
        vt[7]  = '{v: 3'b111, av: 6'd10, cfg: 1'b1, exp: 5'b00011};
        vt[8]  = '{v: 3'b110, av: 6'd2,  cfg: 1'b0, exp: 5'b01001};
        vt[9]  = '{v: 3'b000, av: 6'd10, cfg: 1'b0, exp: 5'b00000};
        vt[10] = '{v: 3'b100, av: 6'd63, cfg: 1'b0, exp: 5'b00101};

        // Reset state
        #12;
        chk("reset_outputs",
            64'({tx_valid, tx_last, tx_cfg_gnt, busy, cpl_ready, wr_ready, rd_ready, drop_count, tx_data}),
            64'd0);
        do_reset();

        // Table-driven arbitration decisions
        for (int i = 0; i < 11; i++) begin
            do_reset();
            tx_ready = 1'b1;
            tx_buf_av = vt[i].av;
            tx_cfg_req = vt[i].cfg;
            for (int s = 0; s < 3; s++) begin
                sv[s] = vt[i].v[s]; sl[s] = 1'b0; sd[s] = 32'h5000_0000 + 32'(s);
            end
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i), 64'({cpl_ready, wr_ready, rd_ready, tx_cfg_gnt, busy}), 64'(vt[i].exp));
            if (vt[i].exp[0] && !vt[i].exp[1])
                chk($sformatf("vec%0d_data", i), 64'(tx_data),
                    64'(32'h5000_0000 + (vt[i].exp[4] ? 32'd0 : vt[i].exp[3] ? 32'd1 : 32'd2)));
        end

        // 1. Round-robin with back-to-back TLPs
        do_reset();
        tx_ready = 1'b1; tx_buf_av = 6'd10;
        mon_en = 1'b1; gap_en = 1'b1;
        for (int t = 0; t < 2; t++) begin
            load(0, 3, t);
            load(1, 3, t);
            load(2, 3, t);
        end
        drv_en = 1'b1;
        wait_drain("rr_drain", 200);
        chk("rr_beats", 64'(hs_count), 64'd18);

        // 2. Buffer gating on rd, then release
        do_reset();
        tx_ready = 1'b1; tx_buf_av = 6'd2;
        sv[2] = 1'b1; sd[2] = 32'hD00D_0002; sl[2] = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("gate_rd_av2", 64'({busy, rd_ready}), 64'd0);
        tx_buf_av = 6'd4;
        @(posedge clk); #1;
        chk("gate_rd_av4", 64'({busy, rd_ready, tx_data}), 64'({2'b11, 32'hD00D_0002}));
        @(posedge clk); #1;
        sv[2] = 1'b0; sl[2] = 1'b0;
        chk("gate_rd_done", 64'(busy), 64'd0);

        // 3. Config request raised mid-TLP
        do_reset();
        tx_ready = 1'b1; tx_buf_av = 6'd10; mon_en = 1'b1;
        load(1, 4, 7);
        drv_en = 1'b1;
        wait_hs(1, 50);
        @(posedge clk); #1;
        tx_cfg_req = 1'b1;
        begin
            int n = 0;
            logic gnt_seen = 1'b0;
            while (hs_count < 4 && n < 50) begin
                @(negedge clk); #1;
                if (tx_cfg_gnt) gnt_seen = 1'b1;
                n++;
            end
            chk("cfg_tlp_complete", 64'(hs_count), 64'd4);
            chk("cfg_no_gnt_midtlp", 64'(gnt_seen), 64'd0);
        end
        @(negedge clk); #1;
        chk("cfg_idle_cycle", 64'({tx_cfg_gnt, busy}), 64'b00);
        @(negedge clk); #1;
        chk("cfg_gnt", 64'({tx_cfg_gnt, busy, tx_valid}), 64'b110);
        repeat (3) begin @(negedge clk); #1; end
        chk("cfg_gnt_held", 64'(tx_cfg_gnt), 64'd1);
        @(posedge clk); #1;
        tx_cfg_req = 1'b0;
        @(posedge clk); #1;
        chk("cfg_release", 64'({tx_cfg_gnt, busy}), 64'b00);

        // 4. Backpressure on a 5-beat completion
        do_reset();
        tx_buf_av = 6'd10; tx_ready = 1'b1; mon_en = 1'b1;
        load(0, 5, 3);
        drv_en = 1'b1; tog_en = 1'b1;
        wait_drain("bp_drain", 100);
        tog_en = 1'b0;
        chk("bp_beats", 64'(hs_count), 64'd5);

        // 5. Reset during beat 2, then cpl wins the first grant
        do_reset();
        tx_ready = 1'b1; tx_buf_av = 6'd10; mon_en = 1'b1;
        load(0, 4, 9);
        drv_en = 1'b1;
        wait_hs(1, 50);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rst_midtlp_outputs",
            64'({tx_valid, tx_last, tx_cfg_gnt, busy, cpl_ready, wr_ready, rd_ready, tx_data}), 64'd0);
        clear_src();
        @(posedge clk); #1;
        rst_n = 1'b1;
        hs_count = 0;
        @(posedge clk); #1;
        load(0, 2, 10);
        load(1, 2, 10);
        drv_en = 1'b1;
        wait_drain("rst_rearb_drain", 50);

        // 6. drop_count saturation
        do_reset();
        for (int i = 1; i <= 300; i++) begin
            tx_err_drop = 1'b1;
            @(posedge clk); #1;
            tx_err_drop = 1'b0;
            @(posedge clk); #1;
            if (i == 100) chk("drop_100", 64'(drop_count), 64'd100);
            if (i == 255) chk("drop_255", 64'(drop_count), 64'd255);
        end
        chk("drop_sat", 64'(drop_count), 64'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
